// File: rtl/fetch_prefetch_if.sv
// Bus bundle between the fetch front end, the instruction memory port and decode.
// The master side is the fetch unit: it drives memory requests and the decode-facing
// head entry; the slave side is the environment (memory + decode).
interface fetch_prefetch_if #(
    parameter int XLEN = 64
);
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_resp_valid;
    logic [31:0]     mem_resp_data;
    logic            mem_resp_err;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    logic            out_err;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_data, mem_resp_err,
        output out_valid, out_inst, out_pc, out_err,
        input  out_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_data, mem_resp_err,
        input  out_valid, out_inst, out_pc, out_err,
        output out_ready
    );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction fetch front end: pipelined in-order requests to instruction memory,
// responses buffered in a small FIFO toward decode. A redirect flushes the FIFO and
// drops the responses still in flight by counting them off.
module fetch_prefetch #(
    parameter int              XLEN      = 64,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(64'h1000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_en,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic              bj_en,
    input  logic [XLEN-1:0]   bj_pc,
    fetch_prefetch_if.master  bus,
    output logic              busy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(MAX_OUTST + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(DEPTH + MAX_OUTST + 1) + 1;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic            err;
    } entry_t;

    entry_t          fifo_mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [IW-1:0]   inflight, discard;
    logic            err_halt;
    logic [XLEN-1:0] fetch_pc, resp_pc;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            credit_ok;
    logic            fire, push, pop;
    entry_t          head;

    // Redirect decode, issue credit, handshakes and the decode-facing head view.
    always_comb begin
        // NOTE: every signal gets a default at the top of the block so no path leaves
        // one unassigned, which would otherwise infer a latch.
        redirect  = trap_en | bj_en;
        target    = trap_en ? trap_pc : bj_pc;
        // Slots already owed to non-discarded in-flight responses count as used, so a
        // returning response always finds room in the FIFO.
        credit_ok = (SW'(count) + SW'(inflight) - SW'(discard)) < SW'(DEPTH);

        bus.mem_req_valid = !rst && !redirect && !err_halt &&
                            (inflight < IW'(MAX_OUTST)) && credit_ok;
        bus.mem_req_addr  = fetch_pc;
        fire = bus.mem_req_valid && bus.mem_req_ready;
        push = !rst && !redirect && bus.mem_resp_valid && (discard == '0);

        head          = fifo_mem[rd_ptr];
        bus.out_valid = (count != '0) && !redirect;
        bus.out_inst  = (count != '0) ? head.inst : '0;
        bus.out_pc    = (count != '0) ? head.pc   : '0;
        bus.out_err   = (count != '0) ? head.err  : 1'b0;
        pop  = bus.out_valid && bus.out_ready;

        busy = (inflight != '0);
    end

    // FIFO storage write on accepted responses.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; count gates every read, so stale
        // contents are never visible and the array can map onto plain RAM.
        if (push) begin
            fifo_mem[wr_ptr] <= '{inst: bus.mem_resp_data, pc: resp_pc, err: bus.mem_resp_err};
        end
    end

    // Control state: PCs, FIFO pointers, in-flight and discard counters, error halt.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
            err_halt <= 1'b0;
        end else if (redirect) begin
            // Flush and restart; everything still in flight after this edge is stale.
            fetch_pc <= target;
            resp_pc  <= target;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= inflight - IW'(bus.mem_resp_valid);
            discard  <= inflight - IW'(bus.mem_resp_valid);
            err_halt <= 1'b0;
        end else begin
            if (fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            inflight <= inflight + IW'(fire) - IW'(bus.mem_resp_valid);
            if (bus.mem_resp_valid && (discard != '0)) begin
                discard <= discard - IW'(1);
            end
            if (push) begin
                wr_ptr  <= wr_ptr + PW'(1);
                resp_pc <= resp_pc + XLEN'(4);
                if (bus.mem_resp_err) begin
                    err_halt <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule
